// File: rtl/binary_morph_3x3_pkg.sv
// Shared definitions for the 3x3 binary morphology stage: op encodings and video coordinate width.
package binary_morph_3x3_pkg;

  localparam int XY_W = 12;

  typedef enum logic [1:0] {
    MORPH_BYPASS = 2'b00,
    MORPH_ERODE  = 2'b01,
    MORPH_DILATE = 2'b10,
    MORPH_EDGE   = 2'b11
  } morph_mode_e;

endpackage

// File: rtl/binary_morph_3x3_line_buf_1b.sv
// One-bit-wide simple dual-port line buffer, synchronous read, read-first on address collision.
module line_buf_1b #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata
);

  logic mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/binary_morph_3x3.sv
// 3x3 binary morphology (bypass/erode/dilate/edge) on a thresholded pixel stream, 2-clock latency.
module binary_morph_3x3
  import binary_morph_3x3_pkg::*;
#(
  parameter int AW        = 10,
  parameter bit VS_ACTIVE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_hs,
  input  logic            i_vs,
  input  logic            i_de,
  input  logic            i_bin,
  input  logic [XY_W-1:0] i_x,
  input  logic [XY_W-1:0] i_y,
  input  logic [1:0]      mode,
  output logic            o_bin,
  output logic [23:0]     o_data,
  output logic            o_hs,
  output logic            o_vs,
  output logic            o_de,
  output logic [XY_W-1:0] o_x,
  output logic [XY_W-1:0] o_y
);

  logic            lb0_rd, lb1_rd;
  logic            bin_p0, hs_p0, vs_p0, de_p0;
  logic [XY_W-1:0] x_p0, y_p0;
  logic            vs_prev;
  morph_mode_e     mode_q;
  logic [5:0]      win_p1;
  logic [2:0]      col_p0;
  logic [8:0]      window;
  logic            border;
  logic            bin_nxt;

  function automatic logic morph_op(input logic [8:0] w, input morph_mode_e m);
    logic res;
    case (m)
      MORPH_BYPASS: res = w[4];
      MORPH_ERODE:  res = &w;
      MORPH_DILATE: res = |w;
      MORPH_EDGE:   res = (|w) & ~(&w);
      default:      res = 1'b0;
    endcase
    return res;
  endfunction

  // lb0 holds row y-1; lb1 is refilled from lb0's output one cycle later, so it holds row y-2.
  line_buf_1b #(.AW(AW)) u_lb0 (
    .clk   (clk),
    .re    (i_de),
    .raddr (i_x[AW-1:0]),
    .rdata (lb0_rd),
    .we    (i_de),
    .waddr (i_x[AW-1:0]),
    .wdata (i_bin)
  );

  line_buf_1b #(.AW(AW)) u_lb1 (
    .clk   (clk),
    .re    (i_de),
    .raddr (i_x[AW-1:0]),
    .rdata (lb1_rd),
    .we    (de_p0),
    .waddr (x_p0[AW-1:0]),
    .wdata (lb0_rd)
  );

  // Stage p0: current column (rows y, y-1, y-2) aligned with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_p0  <= 1'b0;
      hs_p0   <= 1'b0;
      vs_p0   <= 1'b0;
      de_p0   <= 1'b0;
      x_p0    <= '0;
      y_p0    <= '0;
      vs_prev <= ~VS_ACTIVE;
      mode_q  <= MORPH_BYPASS;
    end else begin
      bin_p0  <= i_bin;
      hs_p0   <= i_hs;
      vs_p0   <= i_vs;
      de_p0   <= i_de;
      x_p0    <= i_x;
      y_p0    <= i_y;
      vs_prev <= i_vs;
      if (i_vs == VS_ACTIVE && vs_prev != VS_ACTIVE) mode_q <= morph_mode_e'(mode);
    end
  end

  assign col_p0  = {lb1_rd, lb0_rd, bin_p0};
  assign window  = {win_p1, col_p0};
  assign border  = (x_p0 < XY_W'(2)) || (y_p0 < XY_W'(2));
  assign bin_nxt = de_p0 && !border && morph_op(window, mode_q);

  // Stage p1: window shift and registered result; stale columns at line start are hidden by the border mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p1 <= '0;
      o_bin  <= 1'b0;
      o_hs   <= 1'b0;
      o_vs   <= 1'b0;
      o_de   <= 1'b0;
      o_x    <= '0;
      o_y    <= '0;
    end else begin
      if (de_p0) win_p1 <= {win_p1[2:0], col_p0};
      o_bin <= bin_nxt;
      o_hs  <= hs_p0;
      o_vs  <= vs_p0;
      o_de  <= de_p0;
      o_x   <= x_p0;
      o_y   <= y_p0;
    end
  end

  assign o_data = {24{o_bin}};

endmodule

// File: tb/tb_binary_morph_3x3.sv
// Directed bench for binary_morph_3x3 on a 16x8 frame with 4-cycle horizontal blanking.
module tb_binary_morph_3x3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0, i_bin = 1'b0;
  logic [11:0] i_x = '0, i_y = '0;
  logic [1:0]  mode = 2'b00;
  logic        o_bin, o_hs, o_vs, o_de;
  logic [23:0] o_data;
  logic [11:0] o_x, o_y;

  binary_morph_3x3 dut (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_bin(i_bin),
    .i_x(i_x), .i_y(i_y), .mode(mode), .o_bin(o_bin), .o_data(o_data),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_x(o_x), .o_y(o_y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs, vs, de;
    logic [11:0] x, y;
    logic        bin;
  } ent_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] img [0:7];
  logic [1:0]  frame_mode = 2'b00;
  ent_t        hist0 = '0, hist1 = '0;
  bit          chk_en = 1'b0;
  int          ones_cnt = 0;
  int          spot_x = 0, spot_y = 0;
  logic [23:0] spot_data = 24'h123456;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_pix(input int x, input int y, input logic [1:0] m);
    logic a, o;
    if (x < 2 || y < 2) return 1'b0;
    a = 1'b1;
    o = 1'b0;
    for (int yy = y - 2; yy <= y; yy++)
      for (int xx = x - 2; xx <= x; xx++) begin
        a = a & img[yy][xx];
        o = o | img[yy][xx];
      end
    case (m)
      2'b00:   return img[y-1][x-1];
      2'b01:   return a;
      2'b10:   return o;
      default: return o & ~a;
    endcase
  endfunction

  task automatic drive_cycle(input logic hs, input logic vs, input logic de, input int x, input int y);
    ent_t e;
    @(negedge clk);
    if (chk_en) begin
      chk("sync", {37'd0, o_hs, o_vs, o_de, o_x, o_y},
          {37'd0, hist1.hs, hist1.vs, hist1.de, hist1.x, hist1.y});
      chk("bin", {63'd0, o_bin}, {63'd0, hist1.bin});
      chk("data", {40'd0, o_data}, {40'd0, {24{hist1.bin}}});
      if (o_bin === 1'b1) ones_cnt++;
      if (hist1.de && int'(hist1.x) == spot_x && int'(hist1.y) == spot_y) spot_data = o_data;
    end
    i_hs  = hs;
    i_vs  = vs;
    i_de  = de;
    i_x   = 12'(x);
    i_y   = 12'(y);
    i_bin = de ? img[y][x] : 1'b0;
    e.hs  = hs;
    e.vs  = vs;
    e.de  = de;
    e.x   = 12'(x);
    e.y   = 12'(y);
    e.bin = de ? exp_pix(x, y, frame_mode) : 1'b0;
    hist1 = hist0;
    hist0 = e;
  endtask

  task automatic drive_frame(input logic [1:0] m_start, input logic [1:0] m_sw, input int sw_row,
                             input int sx, input int sy);
    mode       = m_start;
    frame_mode = m_start;
    ones_cnt   = 0;
    spot_x     = sx;
    spot_y     = sy;
    spot_data  = 24'h123456;
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);
    for (int y = 0; y < 8; y++) begin
      if (y == sw_row) mode = m_sw;
      for (int x = 0; x < 16; x++) drive_cycle(1'b0, 1'b0, 1'b1, x, y);
      for (int i = 0; i < 4; i++) drive_cycle((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic img_clear();
    for (int y = 0; y < 8; y++) img[y] = 16'h0000;
  endtask

  task automatic img_fill();
    for (int y = 0; y < 8; y++) img[y] = 16'hFFFF;
  endtask

  task automatic img_block();
    img_clear();
    for (int y = 2; y <= 4; y++) img[y] = 16'h00E0;
  endtask

  initial begin
    img_clear();
    img[3][10] = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_bin", {63'd0, o_bin}, 64'd0);
    chk("rst_data", {40'd0, o_data}, 64'd0);
    chk("rst_sync", {37'd0, o_hs, o_vs, o_de, o_x, o_y}, 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: bypass, single pixel
    drive_frame(2'b00, 2'b00, -1, 11, 4);
    chk("s1_count", 64'(ones_cnt), 64'd1);
    chk("s1_spot", {40'd0, spot_data}, 64'hFFFFFF);

    // 2: dilate, single pixel
    drive_frame(2'b10, 2'b10, -1, 12, 5);
    chk("s2_count", 64'(ones_cnt), 64'd9);
    chk("s2_spot", {40'd0, spot_data}, 64'hFFFFFF);

    // 3: erode single pixel, then 3x3 block
    drive_frame(2'b01, 2'b01, -1, 11, 4);
    chk("s3a_count", 64'(ones_cnt), 64'd0);
    img_block();
    drive_frame(2'b01, 2'b01, -1, 7, 4);
    chk("s3b_count", 64'(ones_cnt), 64'd1);
    chk("s3b_spot", {40'd0, spot_data}, 64'hFFFFFF);

    // 4: all-ones frame under edge, then dilate
    img_fill();
    drive_frame(2'b11, 2'b11, -1, 8, 4);
    chk("s4a_count", 64'(ones_cnt), 64'd0);
    drive_frame(2'b10, 2'b10, -1, 1, 5);
    chk("s4b_count", 64'(ones_cnt), 64'd84);
    chk("s4b_border", {40'd0, spot_data}, 64'd0);

    // 5: erode -> dilate switch mid-frame only applies next frame
    img_block();
    drive_frame(2'b01, 2'b10, 4, 7, 4);
    chk("s5a_count", 64'(ones_cnt), 64'd1);
    frame_mode = 2'b10;
    drive_frame(2'b10, 2'b10, -1, 9, 6);
    chk("s5b_count", 64'(ones_cnt), 64'd25);
    chk("s5b_spot", {40'd0, spot_data}, 64'hFFFFFF);

    // 6: reset mid-line, then two dilate frames
    img_clear();
    img[3][10] = 1'b1;
    mode       = 2'b10;
    frame_mode = 2'b10;
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);
    for (int x = 0; x < 8; x++) drive_cycle(1'b0, 1'b0, 1'b1, x, 2);
    @(negedge clk);
    rst_n  = 1'b0;
    chk_en = 1'b0;
    i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_bin = 1'b0; i_x = '0; i_y = '0;
    @(negedge clk);
    chk("s6_rst_bin", {63'd0, o_bin}, 64'd0);
    chk("s6_rst_de", {63'd0, o_de}, 64'd0);
    chk("s6_rst_hs", {63'd0, o_hs}, 64'd0);
    chk("s6_rst_vs", {63'd0, o_vs}, 64'd0);
    chk("s6_rst_x", {52'd0, o_x}, 64'd0);
    chk("s6_rst_y", {52'd0, o_y}, 64'd0);
    hist0 = '0;
    hist1 = '0;
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);
    chk_en = 1'b1;
    drive_frame(2'b10, 2'b10, -1, 12, 5);
    drive_frame(2'b10, 2'b10, -1, 10, 3);
    chk("s6_count", 64'(ones_cnt), 64'd9);
    chk("s6_spot", {40'd0, spot_data}, 64'hFFFFFF);
    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
